tmds_word_align: RTL

- Sits between the per-channel 1:10 deserializer and the TMDS decoder on the DVI/HDMI receive path.
- Takes raw 10-bit words whose symbol boundary is unknown and locks onto the boundary by hunting for runs of control tokens C0..C3 during blanking.
- Emits boundary-aligned TMDS characters, a control-token flag and a lock indication to the decode stage.
- Alignment uses an internal 20-bit window; no external bitslip.

---
 rtl/tmds_word_align.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tmds_word_align.sv
// TMDS symbol boundary aligner: hunts for runs of control tokens in a sliding
// 20-bit window and emits boundary-aligned 10-bit characters with lock status.
module tmds_word_align #(
    parameter int MIN_TOKENS   = 8,
    parameter int SEARCH_WORDS = 64,
    parameter int TIMEOUT      = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw_in,
    input  logic       raw_valid,
    output logic [9:0] data_out,
    output logic       data_valid,
    output logic       is_ctrl,
    output logic       locked,
    output logic [3:0] offset
);

    // state  | meaning
    // SEARCH | no boundary; count misses, step offset every SEARCH_WORDS misses
    // CHECK  | token seen at current offset; confirming a run of MIN_TOKENS
    // LOCKED | boundary found; token runs refresh the timeout counter
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [7:0]  MIN_T  = 8'(MIN_TOKENS);
    localparam logic [15:0] MISS_T = 16'(SEARCH_WORDS);
    localparam logic [15:0] TMO_T  = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic [9:0]  prev;
    logic [15:0] miss, miss_nxt;
    logic [15:0] tmo, tmo_nxt;
    logic [7:0]  run, run_nxt;
    logic [3:0]  offset_nxt;
    logic [19:0] cat_shift;
    logic [9:0]  win;
    logic        win_tok;
    logic [7:0]  run_inc;
    logic [15:0] miss_inc;
    logic [15:0] tmo_inc;
    logic [3:0]  offset_inc;

    // prev is the older word, so it occupies the low (earlier) bits.
    assign cat_shift = {raw_in, prev} >> offset;
    assign win       = cat_shift[9:0];
    assign win_tok   = (win == 10'b1101010100) || (win == 10'b0010101011) ||
                       (win == 10'b0101010100) || (win == 10'b1010101011);

    assign run_inc    = run + 8'd1;
    assign miss_inc   = miss + 16'd1;
    assign tmo_inc    = tmo + 16'd1;
    assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

    assign locked = (state == LOCKED);

    always_comb begin
        state_nxt  = state;
        miss_nxt   = miss;
        run_nxt    = run;
        tmo_nxt    = tmo;
        offset_nxt = offset;
        if (raw_valid) begin
            case (state)
                SEARCH: begin
                    if (win_tok) begin
                        run_nxt   = 8'd1;
                        miss_nxt  = 16'd0;
                        state_nxt = CHECK;
                    end else if (miss_inc == MISS_T) begin
                        miss_nxt   = 16'd0;
                        offset_nxt = offset_inc;
                    end else begin
                        miss_nxt = miss_inc;
                    end
                end
                CHECK: begin
                    if (!win_tok) begin
                        run_nxt   = 8'd0;
                        miss_nxt  = 16'd1;
                        state_nxt = SEARCH;
                    end else if (run_inc == MIN_T) begin
                        run_nxt   = 8'd0;
                        tmo_nxt   = 16'd0;
                        state_nxt = LOCKED;
                    end else begin
                        run_nxt = run_inc;
                    end
                end
                LOCKED: begin
                    // A refresh on the same word as the timeout keeps lock.
                    if (win_tok && run_inc == MIN_T) begin
                        run_nxt = 8'd0;
                        tmo_nxt = 16'd0;
                    end else if (tmo_inc == TMO_T) begin
                        run_nxt    = 8'd0;
                        tmo_nxt    = 16'd0;
                        miss_nxt   = 16'd0;
                        offset_nxt = offset_inc;
                        state_nxt  = SEARCH;
                    end else begin
                        run_nxt = win_tok ? run_inc : 8'd0;
                        tmo_nxt = tmo_inc;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SEARCH;
            offset     <= 4'd0;
            prev       <= 10'd0;
            miss       <= 16'd0;
            run        <= 8'd0;
            tmo        <= 16'd0;
            data_out   <= 10'd0;
            data_valid <= 1'b0;
            is_ctrl    <= 1'b0;
        end else begin
            state      <= state_nxt;
            offset     <= offset_nxt;
            miss       <= miss_nxt;
            run        <= run_nxt;
            tmo        <= tmo_nxt;
            data_valid <= raw_valid;
            if (raw_valid) begin
                prev     <= raw_in;
                data_out <= win;
                is_ctrl  <= win_tok;
            end
        end
    end

endmodule
